// File: rtl/uart_rx_16x.sv
// uart_rx_16x: 16x-oversampling UART receiver, 8 data bits, optional parity bit, 1 stop bit.
// Build option: define UART_RX_PARITY_EN to include the parity state and checker; without it
// every frame is 8N1, parity_en/parity_odd are ignored and parity_err stays low.
// Received bytes are presented with a valid/ready handshake; a frame that completes while an
// unaccepted byte is still held is dropped and flagged through the sticky overrun output.
module uart_rx_16x #(
    parameter int unsigned CLK_DIV = 27
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       parity_en,
    input  logic       parity_odd,
    input  logic       data_ready,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned TICK_W = 4;
    localparam int unsigned BIT_W  = 3;
    localparam int unsigned DATA_W = 8;

    // Start bit is confirmed half a bit in; every later sample is one full bit after the last.
    localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(7);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(15);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_W - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    state_t state;
    state_t state_next;

    logic              rx_meta;
    logic              rx_sync;
    logic [1:0]        sync_vld;
    logic              armed;

    logic [DIV_W-1:0]  div_cnt;
    logic              tick_c;
    logic [TICK_W-1:0] tick_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift_reg;

    logic              start_det_c;
    logic              sample_c;
    logic              tick_clr_c;
    logic              tick_inc_c;
    logic              start_ok_c;
    logic              shift_c;
    logic              done_c;
    logic              par_err_c;
    logic              load_c;
    logic              drop_c;
    logic              handshake_c;

`ifdef UART_RX_PARITY_EN
    logic              par_cap_c;
    logic              par_en_q;
    logic              par_odd_q;
    logic              par_bit;
`endif

    // Two-flop synchronizer; armed only after a genuinely sampled high line following reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
            sync_vld <= 2'b00;
            armed    <= 1'b0;
        end else begin
            rx_meta  <= rx;
            rx_sync  <= rx_meta;
            sync_vld <= {sync_vld[0], 1'b1};
            if (sync_vld[1] && rx_sync) begin
                armed <= 1'b1;
            end
        end
    end

    // Oversample divider: one-clock tick every CLK_DIV clocks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign tick_c      = (div_cnt == DIV_LAST);
    assign start_det_c = tick_c && armed && !rx_sync;
    assign sample_c    = tick_c && (tick_cnt == ((state == START) ? MID_TICK : LAST_TICK));

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_det_c) begin
                    state_next = START;
                end
            end
            START: begin
                if (sample_c) begin
                    state_next = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                if (sample_c && (bit_cnt == LAST_BIT)) begin
`ifdef UART_RX_PARITY_EN
                    state_next = par_en_q ? PARITY : STOP;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (sample_c) begin
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (sample_c) begin
                    state_next = rx_sync ? IDLE : BREAK;
                end
            end
            BREAK: begin
                if (rx_sync) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // FSM output decode: counter control and sample strobes for the datapath.
    always_comb begin
        tick_clr_c = 1'b0;
        tick_inc_c = 1'b0;
        start_ok_c = 1'b0;
        shift_c    = 1'b0;
        done_c     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_cap_c  = 1'b0;
`endif
        case (state)
            IDLE: begin
                tick_clr_c = start_det_c;
            end
            START: begin
                tick_clr_c = sample_c;
                tick_inc_c = tick_c && !sample_c;
                start_ok_c = sample_c && !rx_sync;
            end
            DATA: begin
                tick_clr_c = sample_c;
                tick_inc_c = tick_c && !sample_c;
                shift_c    = sample_c;
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                tick_clr_c = sample_c;
                tick_inc_c = tick_c && !sample_c;
                par_cap_c  = sample_c;
            end
`endif
            STOP: begin
                tick_clr_c = sample_c;
                tick_inc_c = tick_c && !sample_c;
                done_c     = sample_c;
            end
            default: begin
                tick_clr_c = 1'b0;
            end
        endcase
    end

    // Tick counter times the position inside the current bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (tick_clr_c) begin
            tick_cnt <= '0;
        end else if (tick_inc_c) begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    // Bit counter and LSB-first shift register for the data bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            if (start_ok_c) begin
                bit_cnt <= '0;
            end else if (shift_c) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
            if (shift_c) begin
                shift_reg <= {rx_sync, shift_reg[DATA_W-1:1]};
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity mode is frozen when the start bit is confirmed; parity bit captured mid-bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            par_bit   <= 1'b0;
        end else begin
            if (start_ok_c) begin
                par_en_q  <= parity_en;
                par_odd_q <= parity_odd;
            end
            if (par_cap_c) begin
                par_bit <= rx_sync;
            end
        end
    end

    assign par_err_c = par_en_q && (((^shift_reg) ^ par_bit) != par_odd_q);
`else
    logic unused_parity;
    assign unused_parity = parity_en ^ parity_odd;
    assign par_err_c     = 1'b0;
`endif

    assign handshake_c = data_valid && data_ready;
    assign load_c      = done_c && (!data_valid || data_ready);
    assign drop_c      = done_c && data_valid && !data_ready;

    // Output holding register with valid/ready handshake and sticky overrun.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data       <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (load_c) begin
                data       <= shift_reg;
                parity_err <= par_err_c;
                frame_err  <= !rx_sync;
                data_valid <= 1'b1;
            end else if (handshake_c) begin
                data_valid <= 1'b0;
            end
            if (drop_c) begin
                overrun <= 1'b1;
            end else if (handshake_c) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
